decode_stage: RTL and testbench

//  Registered RV32I/RV64I instruction-decode pipeline stage with valid/ready handshake.

---
 rtl/decode_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// decode_stage : registered RV32I/RV64I decode stage, valid/ready handshake,
//                optional 2-entry skid buffer on the upstream ready path.
// Revision     : 1.0
// ============================================================================
module decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_in_inst,
    input  logic [PC_W-1:0] i_in_pc,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [PC_W-1:0] o_out_pc,
    output logic [6:0]      o_out_opcode,
    output logic [2:0]      o_out_fun3,
    output logic [6:0]      o_out_fun7,
    output logic [4:0]      o_out_rs1,
    output logic [4:0]      o_out_rs2,
    output logic [4:0]      o_out_rd,
    output logic [XLEN-1:0] o_out_imm,
    output logic [2:0]      o_out_type,
    output logic            o_out_illegal
);

    localparam logic [6:0] c_OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] c_OPC_MISC    = 7'b0001111;
    localparam logic [6:0] c_OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] c_OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] c_OPC_STORE   = 7'b0100011;
    localparam logic [6:0] c_OPC_OP      = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI     = 7'b0110111;
    localparam logic [6:0] c_OPC_OP32    = 7'b0111011;
    localparam logic [6:0] c_OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] c_OPC_JALR    = 7'b1100111;
    localparam logic [6:0] c_OPC_JAL     = 7'b1101111;
    localparam logic [6:0] c_OPC_SYSTEM  = 7'b1110011;

    localparam logic [2:0] c_FMT_R    = 3'd0;
    localparam logic [2:0] c_FMT_I    = 3'd1;
    localparam logic [2:0] c_FMT_S    = 3'd2;
    localparam logic [2:0] c_FMT_B    = 3'd3;
    localparam logic [2:0] c_FMT_U    = 3'd4;
    localparam logic [2:0] c_FMT_J    = 3'd5;
    localparam logic [2:0] c_FMT_NONE = 3'd7;

    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } dec_t;

    dec_t        w_dec;
    dec_t        w_m_src;
    dec_t        r_m;
    logic        w_m_load;
    logic [2:0]  w_fmt;
    logic [31:0] w_imm32;

    // Every recognised opcode ends in 2'b11, so a compressed encoding
    // (inst[1:0] != 2'b11) can never match and falls to the illegal default.
    always_comb begin
        w_fmt   = c_FMT_NONE;
        w_imm32 = '0;
        case (i_in_inst[6:0])
            c_OPC_OP:      w_fmt = c_FMT_R;
            c_OPC_OP32:    if (XLEN == 64) w_fmt = c_FMT_R;
            c_OPC_JALR,
            c_OPC_LOAD,
            c_OPC_OPIMM,
            c_OPC_MISC,
            c_OPC_SYSTEM:  w_fmt = c_FMT_I;
            c_OPC_OPIMM32: if (XLEN == 64) w_fmt = c_FMT_I;
            c_OPC_STORE:   w_fmt = c_FMT_S;
            c_OPC_BRANCH:  w_fmt = c_FMT_B;
            c_OPC_LUI,
            c_OPC_AUIPC:   w_fmt = c_FMT_U;
            c_OPC_JAL:     w_fmt = c_FMT_J;
            default:       w_fmt = c_FMT_NONE;
        endcase

        case (w_fmt)
            c_FMT_I: w_imm32 = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
            c_FMT_S: w_imm32 = {{20{i_in_inst[31]}}, i_in_inst[31:25], i_in_inst[11:7]};
            c_FMT_B: w_imm32 = {{19{i_in_inst[31]}}, i_in_inst[31], i_in_inst[7],
                                i_in_inst[30:25], i_in_inst[11:8], 1'b0};
            c_FMT_U: w_imm32 = {i_in_inst[31:12], 12'b0};
            c_FMT_J: w_imm32 = {{11{i_in_inst[31]}}, i_in_inst[31], i_in_inst[19:12],
                                i_in_inst[20], i_in_inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase

        w_dec.inst      = i_in_inst;
        w_dec.pc        = i_in_pc;
        w_dec.imm       = {XLEN{w_imm32[31]}};
        w_dec.imm[31:0] = w_imm32;
        w_dec.fmt       = w_fmt;
        w_dec.ill       = (w_fmt == c_FMT_NONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m <= '0;
        end else if (w_m_load) begin
            r_m <= w_m_src;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            localparam logic [1:0] c_ST_EMPTY = 2'd0;
            localparam logic [1:0] c_ST_FULL  = 2'd1;
            localparam logic [1:0] c_ST_SKID  = 2'd2;

            logic [1:0] r_state;
            logic [1:0] w_state_nxt;
            logic       r_in_ready;
            dec_t       r_s;
            logic       w_in_xfer;
            logic       w_out_xfer;
            logic       w_s_load;
            logic       w_m_from_s;

            assign w_in_xfer  = i_in_valid & r_in_ready;
            assign w_out_xfer = (r_state != c_ST_EMPTY) & i_out_ready;

            always_comb begin
                w_state_nxt = r_state;
                w_m_load    = 1'b0;
                w_m_from_s  = 1'b0;
                w_s_load    = 1'b0;
                case (r_state)
                    c_ST_EMPTY: begin
                        if (w_in_xfer) begin
                            w_state_nxt = c_ST_FULL;
                            w_m_load    = 1'b1;
                        end
                    end
                    c_ST_FULL: begin
                        if (w_in_xfer && w_out_xfer) begin
                            w_m_load    = 1'b1;
                        end else if (w_in_xfer) begin
                            w_state_nxt = c_ST_SKID;
                            w_s_load    = 1'b1;
                        end else if (w_out_xfer) begin
                            w_state_nxt = c_ST_EMPTY;
                        end
                    end
                    c_ST_SKID: begin
                        if (w_out_xfer) begin
                            w_state_nxt = c_ST_FULL;
                            w_m_load    = 1'b1;
                            w_m_from_s  = 1'b1;
                        end
                    end
                    default: w_state_nxt = c_ST_EMPTY;
                endcase
                // Branch redirect wins over everything, including a same-cycle accept.
                if (i_flush) begin
                    w_state_nxt = c_ST_EMPTY;
                    w_m_load    = 1'b0;
                    w_s_load    = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state    <= c_ST_EMPTY;
                    r_in_ready <= 1'b1;
                    r_s        <= '0;
                end else begin
                    r_state    <= w_state_nxt;
                    r_in_ready <= (w_state_nxt != c_ST_SKID);
                    if (w_s_load) begin
                        r_s <= w_dec;
                    end
                end
            end

            assign w_m_src     = w_m_from_s ? r_s : w_dec;
            assign o_in_ready  = r_in_ready;
            assign o_out_valid = (r_state != c_ST_EMPTY);
        end else begin : g_noskid
            logic r_valid;
            logic w_in_ready;
            logic w_in_xfer;
            logic w_out_xfer;

            assign w_in_ready = ~r_valid | i_out_ready;
            assign w_in_xfer  = i_in_valid & w_in_ready;
            assign w_out_xfer = r_valid & i_out_ready;
            assign w_m_load   = w_in_xfer & ~i_flush;
            assign w_m_src    = w_dec;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                end else if (i_flush) begin
                    r_valid <= 1'b0;
                end else if (w_in_xfer) begin
                    r_valid <= 1'b1;
                end else if (w_out_xfer) begin
                    r_valid <= 1'b0;
                end
            end

            assign o_in_ready  = w_in_ready;
            assign o_out_valid = r_valid;
        end
    endgenerate

    assign o_out_pc      = r_m.pc;
    assign o_out_opcode  = r_m.inst[6:0];
    assign o_out_fun3    = r_m.inst[14:12];
    assign o_out_fun7    = r_m.inst[31:25];
    assign o_out_rs1     = r_m.inst[19:15];
    assign o_out_rs2     = r_m.inst[24:20];
    assign o_out_rd      = r_m.inst[11:7];
    assign o_out_imm     = r_m.imm;
    assign o_out_type    = r_m.fmt;
    assign o_out_illegal = r_m.ill;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// tb_decode_stage : drives an RV32/SKID=1 and an RV64/SKID=0 decode stage.
// Revision        : 1.0
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    bit          sel = 1'b0;

    always #5 clk = ~clk;

    logic        a_in_ready, a_out_valid, a_ill, b_in_ready, b_out_valid, b_ill;
    logic [31:0] a_pc, b_pc, a_imm;
    logic [63:0] b_imm;
    logic [6:0]  a_op, a_f7, b_op, b_f7;
    logic [2:0]  a_f3, a_typ, b_f3, b_typ;
    logic [4:0]  a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;

    decode_stage #(.XLEN(32), .PC_W(32), .SKID(1)) u_a (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(a_in_ready), .i_in_inst(in_inst), .i_in_pc(in_pc),
        .o_out_valid(a_out_valid), .i_out_ready(out_ready), .o_out_pc(a_pc),
        .o_out_opcode(a_op), .o_out_fun3(a_f3), .o_out_fun7(a_f7),
        .o_out_rs1(a_rs1), .o_out_rs2(a_rs2), .o_out_rd(a_rd),
        .o_out_imm(a_imm), .o_out_type(a_typ), .o_out_illegal(a_ill)
    );

    decode_stage #(.XLEN(64), .PC_W(32), .SKID(0)) u_b (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(b_in_ready), .i_in_inst(in_inst), .i_in_pc(in_pc),
        .o_out_valid(b_out_valid), .i_out_ready(out_ready), .o_out_pc(b_pc),
        .o_out_opcode(b_op), .o_out_fun3(b_f3), .o_out_fun7(b_f7),
        .o_out_rs1(b_rs1), .o_out_rs2(b_rs2), .o_out_rd(b_rd),
        .o_out_imm(b_imm), .o_out_type(b_typ), .o_out_illegal(b_ill)
    );

    // Selected-DUT view: sel=0 -> RV32 skid stage, sel=1 -> RV64 single-register stage.
    logic        m_ovalid, m_iready, m_ill;
    logic [31:0] m_pc;
    logic [63:0] m_imm;
    logic [6:0]  m_op, m_f7;
    logic [2:0]  m_f3, m_typ;
    logic [4:0]  m_rs1, m_rs2, m_rd;

    always_comb begin
        m_ovalid = sel ? b_out_valid : a_out_valid;
        m_iready = sel ? b_in_ready  : a_in_ready;
        m_ill    = sel ? b_ill       : a_ill;
        m_pc     = sel ? b_pc        : a_pc;
        m_imm    = sel ? b_imm       : {32'b0, a_imm};
        m_op     = sel ? b_op        : a_op;
        m_f7     = sel ? b_f7        : a_f7;
        m_f3     = sel ? b_f3        : a_f3;
        m_typ    = sel ? b_typ       : a_typ;
        m_rs1    = sel ? b_rs1       : a_rs1;
        m_rs2    = sel ? b_rs2       : a_rs2;
        m_rd     = sel ? b_rd        : a_rd;
    end

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        bit          x64;
        logic [2:0]  typ;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_pop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decoder written straight from the ISA format rules.
    function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] pc, input bit x64);
        exp_t               e;
        int                 fmt;
        logic signed [11:0] vi;
        logic signed [12:0] vb;
        logic signed [31:0] vu;
        logic signed [20:0] vj;
        longint             v;
        case (i[6:0])
            7'h33:                             fmt = 0;
            7'h3B:                             fmt = x64 ? 0 : 7;
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: fmt = 1;
            7'h1B:                             fmt = x64 ? 1 : 7;
            7'h23:                             fmt = 2;
            7'h63:                             fmt = 3;
            7'h37, 7'h17:                      fmt = 4;
            7'h6F:                             fmt = 5;
            default:                           fmt = 7;
        endcase
        v = 0;
        case (fmt)
            1: begin vi = i[31:20];                                   v = longint'(vi); end
            2: begin vi = {i[31:25], i[11:7]};                        v = longint'(vi); end
            3: begin vb = {i[31], i[7], i[30:25], i[11:8], 1'b0};     v = longint'(vb); end
            4: begin vu = {i[31:12], 12'b0};                          v = longint'(vu); end
            5: begin vj = {i[31], i[19:12], i[20], i[30:21], 1'b0};   v = longint'(vj); end
            default: v = 0;
        endcase
        if (!x64) v = v & 64'hFFFF_FFFF;
        e.inst = i;
        e.pc   = pc;
        e.imm  = v;
        e.typ  = fmt[2:0];
        e.ill  = (fmt == 7);
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops[13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                                 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
        logic [31:0] r = $urandom;
        if ($urandom_range(4) == 0) return r;
        return {r[31:7], ops[$urandom_range(12)]};
    endfunction

    task automatic check_state();
        exp_t e;
        chk("out_valid", m_ovalid, q.size() != 0);
        chk("in_ready", m_iready, sel ? (q.size() == 0 || out_ready) : (q.size() < 2));
        if (q.size() != 0) begin
            e = q[0];
            chk("pc", m_pc, e.pc);
            chk("opcode", m_op, e.inst[6:0]);
            chk("fun3", m_f3, e.inst[14:12]);
            chk("fun7", m_f7, e.inst[31:25]);
            chk("rs1", m_rs1, e.inst[19:15]);
            chk("rs2", m_rs2, e.inst[24:20]);
            chk("rd", m_rd, e.inst[11:7]);
            chk("imm", m_imm, e.imm);
            chk("type", m_typ, e.typ);
            chk("illegal", m_ill, e.ill);
        end
    endtask

    // One clock cycle: drive at the falling edge, predict the rising edge, check at the next fall.
    task automatic step(input bit iv, input logic [31:0] inst, input logic [31:0] pc,
                        input bit ordy, input bit fl, output bit acc);
        in_valid  = iv;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        acc = iv && m_iready && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (m_ovalid && ordy && q.size() != 0) begin
                void'(q.pop_front());
                n_pop++;
            end
            if (acc) q.push_back(ref_dec(inst, pc, sel));
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic select(input bit s);
        bit acc;
        sel = s;
        step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 8 && q.size() != 0; k++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic run_vec(input vec_t v, input logic [31:0] pc);
        bit          acc;
        logic [31:0] t;
        t = v.inst;
        if (v.x64 != sel) select(v.x64);
        step(1'b1, t, pc, 1'b0, 1'b0, acc);
        chk("vec_accept", acc, 1);
        chk("vec_latency", m_ovalid, 1);
        chk("vec_type", m_typ, v.typ);
        chk("vec_imm", m_imm, v.imm);
        chk("vec_illegal", m_ill, v.ill);
        chk("vec_rd", m_rd, t[11:7]);
        chk("vec_rs1", m_rs1, t[19:15]);
        chk("vec_rs2", m_rs2, t[24:20]);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        chk("vec_handshake_done", m_ovalid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[18];
        logic [31:0] s4[4];
        bit          acc;
        int          idx, cyc, pop0;

        tbl[0]  = '{32'hFFF00093, 1'b0, 3'd1, 64'hFFFF_FFFF, 1'b0};
        tbl[1]  = '{32'h00112623, 1'b0, 3'd2, 64'h0000_000C, 1'b0};
        tbl[2]  = '{32'hFE000EE3, 1'b0, 3'd3, 64'hFFFF_FFFC, 1'b0};
        tbl[3]  = '{32'h001000EF, 1'b0, 3'd5, 64'h0000_0800, 1'b0};
        tbl[4]  = '{32'h00000000, 1'b0, 3'd7, 64'h0,         1'b1};
        tbl[5]  = '{32'h0000005B, 1'b0, 3'd7, 64'h0,         1'b1};
        tbl[6]  = '{32'h0000001B, 1'b0, 3'd7, 64'h0,         1'b1};
        tbl[7]  = '{32'h0000003B, 1'b0, 3'd7, 64'h0,         1'b1};
        tbl[8]  = '{32'h00000033, 1'b0, 3'd0, 64'h0,         1'b0};
        tbl[9]  = '{32'hFFFFF297, 1'b0, 3'd4, 64'hFFFF_F000, 1'b0};
        tbl[10] = '{32'h0FF0000F, 1'b0, 3'd1, 64'h0000_00FF, 1'b0};
        tbl[11] = '{32'h80002083, 1'b0, 3'd1, 64'hFFFF_F800, 1'b0};
        tbl[12] = '{32'h00000012, 1'b0, 3'd7, 64'h0,         1'b1};
        tbl[13] = '{32'h800002B7, 1'b1, 3'd4, 64'hFFFF_FFFF_8000_0000, 1'b0};
        tbl[14] = '{32'h0000001B, 1'b1, 3'd1, 64'h0,         1'b0};
        tbl[15] = '{32'h0000003B, 1'b1, 3'd0, 64'h0,         1'b0};
        tbl[16] = '{32'h80002083, 1'b1, 3'd1, 64'hFFFF_FFFF_FFFF_F800, 1'b0};
        tbl[17] = '{32'h00112623, 1'b1, 3'd2, 64'h0000_000C, 1'b0};

        // Reset values
        @(negedge clk);
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_imm", a_imm, 0);
        chk("rst_a_pc", a_pc, 0);
        chk("rst_a_type", a_typ, 0);
        chk("rst_b_valid", b_out_valid, 0);
        chk("rst_b_imm", b_imm, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_a_in_ready", a_in_ready, 1);
        chk("rst_b_in_ready", b_in_ready, 1);
        check_state();

        foreach (tbl[k]) run_vec(tbl[k], 32'h1000 + 32'(k) * 4);

        // Stream 4 instructions into the skid stage with out_ready low for 3 cycles
        select(1'b0);
        s4[0] = 32'h00100093; s4[1] = 32'h00200113; s4[2] = 32'h00112623; s4[3] = 32'h001000EF;
        idx  = 0;
        cyc  = 0;
        pop0 = n_pop;
        while (idx < 4 && cyc < 16) begin
            step(1'b1, s4[idx], 32'h2000 + 32'(idx) * 4, cyc >= 3, 1'b0, acc);
            if (acc) begin
                idx++;
                if (idx == 2) chk("t4_in_ready_drop", m_iready, 0);
            end
            cyc++;
        end
        chk("t4_all_accepted", idx, 4);
        drain();
        chk("t4_delivered", n_pop - pop0, 4);

        // Flush while in the skid state with in_valid held high
        step(1'b1, 32'h00300193, 32'h3000, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00400213, 32'h3004, 1'b0, 1'b0, acc);
        chk("t5_skid_full", m_iready, 0);
        step(1'b1, 32'h00500293, 32'h3008, 1'b0, 1'b1, acc);
        chk("t5_flush_valid", m_ovalid, 0);
        chk("t5_flush_ready", m_iready, 1);
        step(1'b1, 32'h00600313, 32'h300C, 1'b0, 1'b0, acc);
        chk("t5_next_pc", m_pc, 32'h300C);
        drain();

        // Asynchronous reset while two instructions are held
        step(1'b1, 32'h00700393, 32'h4000, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00800413, 32'h4004, 1'b0, 1'b0, acc);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_pc", a_pc, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_state();

        // Randomised traffic against the reference model on both configurations
        for (int s = 0; s < 2; s++) begin
            select(s[0]);
            for (int c = 0; c < 400; c++) begin
                step($urandom_range(3) != 0, rand_inst(), $urandom,
                     $urandom_range(2) != 0, $urandom_range(39) == 0, acc);
            end
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
